// File: rtl/control_unit.sv
// RV32I main decoder: opcode/funct3/funct7 -> datapath controls, registered once.
// Optional `CONTROL_UNIT_ILLEGAL_EN adds a registered `illegal` flag that also forces a NOP.
module control_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic       ru_write,
  output logic [3:0] alu_op,
  output logic [2:0] imm_src,
  output logic       alu_a_src,
  output logic       alu_b_src,
  output logic       dm_write,
  output logic [2:0] dm_ctrl,
  output logic [4:0] br_op,
  output logic [1:0] ru_data_src
`ifdef CONTROL_UNIT_ILLEGAL_EN
  ,
  output logic       illegal
`endif
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_PASS_B = 4'b1111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_U = 3'b010;
  localparam logic [2:0] IMM_B = 3'b101;
  localparam logic [2:0] IMM_J = 3'b110;

  localparam logic [4:0] BR_JUMP = 5'b10000;
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  typedef struct packed {
    logic       ru_write;
    logic [3:0] alu_op;
    logic [2:0] imm_src;
    logic       alu_a_src;
    logic       alu_b_src;
    logic       dm_write;
    logic [2:0] dm_ctrl;
    logic [4:0] br_op;
    logic [1:0] ru_data_src;
  } ctrl_t;

  ctrl_t dec_s;
  ctrl_t nxt_s;
  ctrl_t ctrl_r;
  logic  f3_alt_s;

  // funct3 000 (add/sub) and 101 (srl/sra) are the only encodings where funct7[5] picks a variant
  assign f3_alt_s = (funct3 == 3'b000) || (funct3 == 3'b101);

  // Combinational decode of the instruction fields into the control word
  always_comb begin
    dec_s = '0;
    case (opcode)
      OP_R: begin
        dec_s.ru_write = 1'b1;
        if (f3_alt_s) begin
          dec_s.alu_op = {funct7[5], funct3};
        end else begin
          dec_s.alu_op = {1'b0, funct3};
        end
      end
      OP_I_ALU: begin
        dec_s.ru_write  = 1'b1;
        dec_s.alu_b_src = 1'b1;
        dec_s.imm_src   = IMM_I;
        // addi has no subtract form, so only the shift-right group looks at funct7
        if (funct3 == 3'b101) begin
          dec_s.alu_op = {funct7[5], 3'b101};
        end else begin
          dec_s.alu_op = {1'b0, funct3};
        end
      end
      OP_LOAD: begin
        dec_s.ru_write    = 1'b1;
        dec_s.alu_b_src   = 1'b1;
        dec_s.alu_op      = ALU_ADD;
        dec_s.imm_src     = IMM_I;
        dec_s.dm_ctrl     = funct3;
        dec_s.ru_data_src = WB_MEM;
      end
      OP_STORE: begin
        dec_s.alu_b_src = 1'b1;
        dec_s.alu_op    = ALU_ADD;
        dec_s.imm_src   = IMM_S;
        dec_s.dm_write  = 1'b1;
        dec_s.dm_ctrl   = funct3;
      end
      OP_BRANCH: begin
        dec_s.alu_a_src = 1'b1;
        dec_s.alu_b_src = 1'b1;
        dec_s.alu_op    = ALU_ADD;
        dec_s.imm_src   = IMM_B;
        dec_s.br_op     = {2'b01, funct3};
      end
      OP_JAL: begin
        dec_s.ru_write    = 1'b1;
        dec_s.alu_a_src   = 1'b1;
        dec_s.alu_b_src   = 1'b1;
        dec_s.alu_op      = ALU_ADD;
        dec_s.imm_src     = IMM_J;
        dec_s.br_op       = BR_JUMP;
        dec_s.ru_data_src = WB_PC4;
      end
      OP_JALR: begin
        dec_s.ru_write    = 1'b1;
        dec_s.alu_b_src   = 1'b1;
        dec_s.alu_op      = ALU_ADD;
        dec_s.imm_src     = IMM_I;
        dec_s.br_op       = BR_JUMP;
        dec_s.ru_data_src = WB_PC4;
      end
      OP_LUI: begin
        dec_s.ru_write  = 1'b1;
        dec_s.alu_b_src = 1'b1;
        dec_s.alu_op    = ALU_PASS_B;
        dec_s.imm_src   = IMM_U;
      end
      OP_AUIPC: begin
        dec_s.ru_write  = 1'b1;
        dec_s.alu_a_src = 1'b1;
        dec_s.alu_b_src = 1'b1;
        dec_s.alu_op    = ALU_ADD;
        dec_s.imm_src   = IMM_U;
      end
      default: begin
        dec_s = '0;
      end
    endcase
  end

`ifdef CONTROL_UNIT_ILLEGAL_EN
  logic illegal_s;
  logic illegal_r;

  // Flag unknown opcodes and R-type funct7 encodings outside base RV32I
  always_comb begin
    illegal_s = 1'b0;
    case (opcode)
      OP_R: begin
        if (funct7 == 7'b0000000) begin
          illegal_s = 1'b0;
        end else if (funct7 == 7'b0100000) begin
          illegal_s = !f3_alt_s;
        end else begin
          illegal_s = 1'b1;
        end
      end
      OP_I_ALU, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: begin
        illegal_s = 1'b0;
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
  end

  // An illegal instruction is squashed to the NOP control word
  always_comb begin
    if (illegal_s) begin
      nxt_s = '0;
    end else begin
      nxt_s = dec_s;
    end
  end

  // Illegal flag register, same timing as the control word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_r <= 1'b0;
    end else begin
      illegal_r <= illegal_s;
    end
  end

  assign illegal = illegal_r;
`else
  logic unused_funct7_s;

  // Only funct7[5] matters without legality checking
  assign unused_funct7_s = ^{funct7[6], funct7[4:0]};

  // Control word passes straight through to the register
  always_comb begin
    nxt_s = dec_s;
  end
`endif

  // Output register; reset value is the NOP encoding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_r <= '0;
    end else begin
      ctrl_r <= nxt_s;
    end
  end

  assign ru_write    = ctrl_r.ru_write;
  assign alu_op      = ctrl_r.alu_op;
  assign imm_src     = ctrl_r.imm_src;
  assign alu_a_src   = ctrl_r.alu_a_src;
  assign alu_b_src   = ctrl_r.alu_b_src;
  assign dm_write    = ctrl_r.dm_write;
  assign dm_ctrl     = ctrl_r.dm_ctrl;
  assign br_op       = ctrl_r.br_op;
  assign ru_data_src = ctrl_r.ru_data_src;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: instruction-level model plus directed literal checks.
module tb_control_unit;

`ifdef CONTROL_UNIT_ILLEGAL_EN
  localparam int W = 22;
`else
  localparam int W = 21;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic [6:0] funct7 = 7'd0;
  logic       ru_write;
  logic [3:0] alu_op;
  logic [2:0] imm_src;
  logic       alu_a_src;
  logic       alu_b_src;
  logic       dm_write;
  logic [2:0] dm_ctrl;
  logic [4:0] br_op;
  logic [1:0] ru_data_src;
  logic [W-1:0] dut_vec;
  logic [W-1:0] exp_r = '0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   cmp_en = 1'b0;

`ifdef CONTROL_UNIT_ILLEGAL_EN
  logic illegal;
  assign dut_vec = {illegal, ru_write, alu_op, imm_src, alu_a_src, alu_b_src,
                    dm_write, dm_ctrl, br_op, ru_data_src};
`else
  assign dut_vec = {ru_write, alu_op, imm_src, alu_a_src, alu_b_src,
                    dm_write, dm_ctrl, br_op, ru_data_src};
`endif

  control_unit dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .ru_write(ru_write), .alu_op(alu_op), .imm_src(imm_src),
    .alu_a_src(alu_a_src), .alu_b_src(alu_b_src), .dm_write(dm_write),
    .dm_ctrl(dm_ctrl), .br_op(br_op), .ru_data_src(ru_data_src)
`ifdef CONTROL_UNIT_ILLEGAL_EN
    , .illegal(illegal)
`endif
  );

  always #5 clk = ~clk;

  // Instruction-level reference: what each RV32I class needs from the datapath
  function automatic logic [W-1:0] model(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [6:0] f7);
    logic rw, a, b, dw, bad;
    logic [3:0] aop;
    logic [2:0] imm, dc;
    logic [4:0] br;
    logic [1:0] src;
    logic [20:0] v;
    rw = 1'b0; a = 1'b0; b = 1'b0; dw = 1'b0; bad = 1'b0;
    aop = 4'd0; imm = 3'd0; dc = 3'd0; br = 5'd0; src = 2'd0;
    if (op == 7'b0110011) begin
      rw  = 1'b1;
      aop = {f7[5] & (f3 == 3'd0 || f3 == 3'd5), f3};
      bad = !(f7 == 7'd0 || f7 == 7'd32) || (f7 == 7'd32 && !(f3 == 3'd0 || f3 == 3'd5));
    end else if (op == 7'b0010011) begin
      rw = 1'b1; b = 1'b1;
      aop = {f7[5] & (f3 == 3'd5), f3};
    end else if (op == 7'b0000011) begin
      rw = 1'b1; b = 1'b1; dc = f3; src = 2'd1;
    end else if (op == 7'b0100011) begin
      b = 1'b1; imm = 3'd1; dw = 1'b1; dc = f3;
    end else if (op == 7'b1100011) begin
      a = 1'b1; b = 1'b1; imm = 3'd5; br = 5'd8 + {2'd0, f3};
    end else if (op == 7'b1101111) begin
      rw = 1'b1; a = 1'b1; b = 1'b1; imm = 3'd6; br = 5'd16; src = 2'd2;
    end else if (op == 7'b1100111) begin
      rw = 1'b1; b = 1'b1; br = 5'd16; src = 2'd2;
    end else if (op == 7'b0110111) begin
      rw = 1'b1; b = 1'b1; aop = 4'd15; imm = 3'd2;
    end else if (op == 7'b0010111) begin
      rw = 1'b1; a = 1'b1; b = 1'b1; imm = 3'd2;
    end else begin
      bad = 1'b1;
    end
    v = {rw, aop, imm, a, b, dw, dc, br, src};
`ifdef CONTROL_UNIT_ILLEGAL_EN
    return bad ? {1'b1, 21'd0} : {1'b0, v};
`else
    return (bad && op != 7'b0110011) ? '0 : v;
`endif
  endfunction

  // Model register tracks the DUT's one-cycle latency and async clear
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_r <= '0;
    else        exp_r <= model(opcode, funct3, funct7);
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      n_cmp++;
      if (dut_vec !== exp_r) begin
        n_bad++;
        $display("FAIL model_cmp t=%0t op=%b f3=%b f7=%b: got %h required %h",
                 $time, opcode, funct3, funct7, dut_vec, exp_r);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic apply(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    @(posedge clk);
    #1;
    opcode = op; funct3 = f3; funct7 = f7;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [6:0] ops [12];
    logic [6:0] f7s [4];
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
            7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111, 7'b0000000, 7'b0110001};
    f7s = '{7'b0000000, 7'b0100000, 7'b0000001, 7'b1011111};
    #1 rst_n = 1'b0;
    opcode = 7'b1101111;
    repeat (2) @(posedge clk);
    #1 chk("reset_state", dut_vec, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    apply(7'b0110011, 3'b000, 7'b0100000);
    chk("r_sub_alu", alu_op, 4'b1000);
    chk("r_sub_rw", ru_write, 1);
    chk("r_sub_bsrc", alu_b_src, 0);
    chk("r_sub_src", ru_data_src, 2'b00);

    apply(7'b0110011, 3'b010, 7'b0100000);
`ifdef CONTROL_UNIT_ILLEGAL_EN
    chk("r_slt_f7_illegal", illegal, 1);
    chk("r_slt_f7_nop", dut_vec[20:0], 0);
`else
    chk("r_slt_f7_alu", alu_op, 4'b0010);
    chk("r_slt_f7_rw", ru_write, 1);
`endif

    apply(7'b0010011, 3'b100, 7'b0100000);
    chk("xori_alu", alu_op, 4'b0100);
    chk("xori_bsrc", alu_b_src, 1);
    chk("xori_imm", imm_src, 3'b000);
    apply(7'b0010011, 3'b101, 7'b0100000);
    chk("srai_alu", alu_op, 4'b1101);
    apply(7'b0010011, 3'b000, 7'b0100000);
    chk("addi_not_sub", alu_op, 4'b0000);

    apply(7'b0000011, 3'b101, 7'b1111111);
    chk("load_rw", ru_write, 1);
    chk("load_bsrc", alu_b_src, 1);
    chk("load_dmctrl", dm_ctrl, 3'b101);
    chk("load_src", ru_data_src, 2'b01);
    chk("load_dmw", dm_write, 0);

    apply(7'b0100011, 3'b111, 7'b0000000);
    chk("store_dmw", dm_write, 1);
    chk("store_dmctrl", dm_ctrl, 3'b111);
    chk("store_imm", imm_src, 3'b001);
    chk("store_rw", ru_write, 0);

    apply(7'b1100011, 3'b110, 7'b0000000);
    chk("br_op", br_op, 5'b01110);
    chk("br_imm", imm_src, 3'b101);
    chk("br_asrc", alu_a_src, 1);
    chk("br_rw", ru_write, 0);

    apply(7'b1101111, 3'b000, 7'b0000000);
    chk("jal_br", br_op, 5'b10000);
    chk("jal_imm", imm_src, 3'b110);
    chk("jal_src", ru_data_src, 2'b10);
    chk("jal_asrc", alu_a_src, 1);

    apply(7'b1100111, 3'b000, 7'b0000000);
    chk("jalr_br", br_op, 5'b10000);
    chk("jalr_asrc", alu_a_src, 0);
    chk("jalr_imm", imm_src, 3'b000);
    chk("jalr_src", ru_data_src, 2'b10);

    apply(7'b0110111, 3'b000, 7'b0000000);
    chk("lui_alu", alu_op, 4'b1111);
    chk("lui_imm", imm_src, 3'b010);
    chk("lui_asrc", alu_a_src, 0);

    apply(7'b0010111, 3'b000, 7'b0000000);
    chk("auipc_alu", alu_op, 4'b0000);
    chk("auipc_imm", imm_src, 3'b010);
    chk("auipc_asrc", alu_a_src, 1);

    apply(7'b1111111, 3'b111, 7'b1111111);
    chk("unknown_nop", dut_vec[20:0], 0);

    // Mid-cycle async reset with live, nonzero outputs
    apply(7'b1101111, 3'b000, 7'b0000000);
    chk("pre_reset_live", ru_write, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", dut_vec, 0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(7'b0110011, 3'b101, 7'b0100000);
    chk("post_reset_sra", alu_op, 4'b1101);

    // Back-to-back sweep, checked every cycle by the model compare
    foreach (ops[i]) begin
      for (int f3 = 0; f3 < 8; f3++) begin
        foreach (f7s[k]) begin
          @(posedge clk);
          #1;
          opcode = ops[i]; funct3 = f3[2:0]; funct7 = f7s[k];
        end
      end
    end
    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
